// File: rtl/fc_f6_layer.sv
// fc_f6_layer: LeNet-5 F6 fully-connected stage (N inputs -> M neurons, signed Q16.16).
// Latency: M*(N+2)+1 cycles from accepted start to DONE; one result word per N+2 cycles.
// Backpressure: start/end handshake; waits in WAIT_NEXT while the next stage still owns its memory.
//
// Ports:
//   clk, reset                      - single clock, synchronous active-high reset
//   riscv_data/riscv_address        - weight (index o*N+i) and bias (index o) load port
//   wm_enable_write/bm_enable_write - weight / bias memory write strobes (accepted in any state)
//   ifm_enable_write_previous,
//   data_in_from_previous           - upstream input words, accepted only in IDLE
//   start_from_previous             - input buffer complete; end_to_previous releases it
//   ready                           - high while IDLE
//   end_from_next                   - next stage released its memory
//   data_out_for_next, ofm_enable_write_next,
//   ofm_address_write_next          - registered result write, valid for the WRITE cycle only
//   start_to_next                   - all M results written
//
// Optional feature: define FC_F6_RELU_EN to clamp negative results to zero before writing.
module fc_f6_layer #(
    parameter int DATA_WIDTH        = 32,
    parameter int FRAC_BITS         = 16,
    parameter int ADDRESS_BITS      = 15,
    parameter int NUMBER_OF_INPUTS  = 120,
    parameter int NUMBER_OF_OUTPUTS = 84
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [DATA_WIDTH-1:0]                riscv_data,
    input  logic [ADDRESS_BITS-1:0]              riscv_address,
    input  logic                                 wm_enable_write,
    input  logic                                 bm_enable_write,
    input  logic                                 ifm_enable_write_previous,
    input  logic [DATA_WIDTH-1:0]                data_in_from_previous,
    input  logic                                 start_from_previous,
    output logic                                 end_to_previous,
    output logic                                 ready,
    input  logic                                 end_from_next,
    output logic [DATA_WIDTH-1:0]                data_out_for_next,
    output logic                                 ofm_enable_write_next,
    output logic [$clog2(NUMBER_OF_OUTPUTS)-1:0] ofm_address_write_next,
    output logic                                 start_to_next
);

    localparam int N  = NUMBER_OF_INPUTS;
    localparam int M  = NUMBER_OF_OUTPUTS;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int OW = $clog2(M);
    localparam int WA = $clog2(N * M);

    localparam logic [ADDRESS_BITS-1:0] WM_DEPTH = ADDRESS_BITS'(N * M);
    localparam logic [ADDRESS_BITS-1:0] BM_DEPTH = ADDRESS_BITS'(M);
    localparam logic [IW-1:0]           K_LAST   = IW'(N - 1);
    localparam logic [OW-1:0]           O_LAST   = OW'(M - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_NEXT,
        S_BIAS,
        S_MAC,
        S_WRITE,
        S_DONE
    } state_t;

    // Storage (contents survive reset)
    logic [DATA_WIDTH-1:0] r_wmem [0:N*M-1];
    logic [DATA_WIDTH-1:0] r_bmem [0:M-1];
    logic [DATA_WIDTH-1:0] r_ifm  [0:N-1];

    // Control state
    state_t                r_state;
    logic [OW-1:0]         r_o;
    logic [IW-1:0]         r_k;
    logic [WA-1:0]         r_wbase;     // o*N, advanced by N per neuron
    logic [IW-1:0]         r_wr_ptr;
    logic                  r_next_busy;
    logic signed [DATA_WIDTH-1:0] r_acc;

    // Synchronous read data
    logic signed [DATA_WIDTH-1:0] r_w_q;
    logic signed [DATA_WIDTH-1:0] r_i_q;
    logic signed [DATA_WIDTH-1:0] r_b_q;

    // Registered outputs
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_ofm_en;
    logic [OW-1:0]         r_ofm_addr;
    logic                  r_start_next;
    logic                  r_end_prev;
    logic                  r_ready;

    // Datapath wires
    logic                           w_ifm_we;
    logic [IW-1:0]                  w_rd_idx;
    logic [WA-1:0]                  w_w_rd_addr;
    logic signed [2*DATA_WIDTH-1:0] w_i_ext;
    logic signed [2*DATA_WIDTH-1:0] w_w_ext;
    logic signed [2*DATA_WIDTH-1:0] w_prod_full;
    logic signed [DATA_WIDTH-1:0]   w_prod;
    logic signed [DATA_WIDTH-1:0]   w_acc_next;
    logic [DATA_WIDTH-1:0]          w_result;

    assign w_ifm_we = ifm_enable_write_previous && (r_state == S_IDLE);

    // Index issued this cycle: 0 in BIAS, k+1 in MAC. The final MAC cycle has
    // nothing left to issue, so it reads index 0 to stay inside the memories.
    always_comb begin
        w_rd_idx = '0;
        if (r_state == S_MAC && r_k != K_LAST) begin
            w_rd_idx = r_k + IW'(1);
        end
    end

    assign w_w_rd_addr = r_wbase + WA'(w_rd_idx);

    // Full-width signed product, arithmetic shift back to Q16.16, then truncate.
    assign w_i_ext     = {{DATA_WIDTH{r_i_q[DATA_WIDTH-1]}}, r_i_q};
    assign w_w_ext     = {{DATA_WIDTH{r_w_q[DATA_WIDTH-1]}}, r_w_q};
    assign w_prod_full = w_i_ext * w_w_ext;
    assign w_prod      = DATA_WIDTH'(w_prod_full >>> FRAC_BITS);

    // First MAC cycle seeds the accumulator with the bias; wraps on overflow.
    assign w_acc_next  = ((r_k == '0) ? r_b_q : r_acc) + w_prod;

`ifdef FC_F6_RELU_EN
    assign w_result = w_acc_next[DATA_WIDTH-1] ? '0 : w_acc_next;
`else
    assign w_result = w_acc_next;
`endif

    // Memories: writes plus 1-cycle synchronous reads
    always_ff @(posedge clk) begin
        if (wm_enable_write && (riscv_address < WM_DEPTH)) begin
            r_wmem[WA'(riscv_address)] <= riscv_data;
        end
        if (bm_enable_write && (riscv_address < BM_DEPTH)) begin
            r_bmem[OW'(riscv_address)] <= riscv_data;
        end
        if (w_ifm_we) begin
            r_ifm[r_wr_ptr] <= data_in_from_previous;
        end
        r_w_q <= r_wmem[w_w_rd_addr];
        r_i_q <= r_ifm[w_rd_idx];
        r_b_q <= r_bmem[r_o];
    end

    // Control FSM with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_o          <= '0;
            r_k          <= '0;
            r_wbase      <= '0;
            r_wr_ptr     <= '0;
            r_next_busy  <= 1'b0;
            r_acc        <= '0;
            r_data_out   <= '0;
            r_ofm_en     <= 1'b0;
            r_ofm_addr   <= '0;
            r_start_next <= 1'b0;
            r_end_prev   <= 1'b0;
            r_ready      <= 1'b1;
        end else begin
            r_ofm_en     <= 1'b0;
            r_start_next <= 1'b0;
            r_end_prev   <= 1'b0;

            // Set (our start_to_next) takes priority over clear (end_from_next).
            if (r_start_next) begin
                r_next_busy <= 1'b1;
            end else if (end_from_next) begin
                r_next_busy <= 1'b0;
            end

            if (w_ifm_we) begin
                r_wr_ptr <= (r_wr_ptr == K_LAST) ? '0 : r_wr_ptr + IW'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (start_from_previous) begin
                        r_wr_ptr <= '0;
                        r_o      <= '0;
                        r_wbase  <= '0;
                        r_ready  <= 1'b0;
                        r_state  <= r_next_busy ? S_WAIT_NEXT : S_BIAS;
                    end
                end
                S_WAIT_NEXT: begin
                    // A release arriving this cycle frees the next stage at this edge.
                    if (!r_next_busy || end_from_next) begin
                        r_state <= S_BIAS;
                    end
                end
                S_BIAS: begin
                    r_k     <= '0;
                    r_state <= S_MAC;
                end
                S_MAC: begin
                    r_acc <= w_acc_next;
                    if (r_k == K_LAST) begin
                        r_ofm_en   <= 1'b1;
                        r_data_out <= w_result;
                        r_ofm_addr <= r_o;
                        r_state    <= S_WRITE;
                    end else begin
                        r_k <= r_k + IW'(1);
                    end
                end
                S_WRITE: begin
                    if (r_o != O_LAST) begin
                        r_o     <= r_o + OW'(1);
                        r_wbase <= r_wbase + WA'(N);
                        r_state <= S_BIAS;
                    end else begin
                        r_start_next <= 1'b1;
                        r_end_prev   <= 1'b1;
                        r_state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign data_out_for_next      = r_data_out;
    assign ofm_enable_write_next  = r_ofm_en;
    assign ofm_address_write_next = r_ofm_addr;
    assign start_to_next          = r_start_next;
    assign end_to_previous        = r_end_prev;
    assign ready                  = r_ready;

endmodule

// File: doc/fc_f6_layer.md
# fc_f6_layer

Fully-connected LeNet-5 F6 stage, directly downstream of the C5 convolution stage. It collects the 120 C5 results into an internal input buffer and computes 84 neurons. Each neuron is bias plus the dot product of inputs and weights in signed Q16.16 fixed point, optionally passed through ReLU. Results are written into the next stage's memory, using the same start/end handshake as the rest of the pipeline.

## Interface
Parameters:
- DATA_WIDTH, 32, word width; signed fixed point.
- FRAC_BITS, 16, fractional bits.
- ADDRESS_BITS, 15, RISC-V load address width.
- NUMBER_OF_INPUTS, 120, input vector length N.
- NUMBER_OF_OUTPUTS, 84, neuron count M.

Ports:
- clk  in  1  clock. One clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- riscv_data  in  DATA_WIDTH  weight/bias load data.
- riscv_address  in  ADDRESS_BITS  weight index o*N+i, or bias index o.
- wm_enable_write  in  1  write riscv_data to the weight memory.
- bm_enable_write  in  1  write riscv_data to the bias memory.
- ifm_enable_write_previous  in  1  upstream writes one input word.
- data_in_from_previous  in  DATA_WIDTH  upstream input word.
- start_from_previous  in  1  pulse: input buffer complete.
- end_to_previous  out  1  pulse: input buffer released.
- ready  out  1  high in IDLE.
- end_from_next  in  1  pulse: next stage released its memory.
- data_out_for_next  out  DATA_WIDTH  neuron result.
- ofm_enable_write_next  out  1  result write strobe.
- ofm_address_write_next  out  $clog2(NUMBER_OF_OUTPUTS)  result index o.
- start_to_next  out  1  pulse: outputs complete.

## Operation
- Input buffer: N words. The write pointer increments on each accepted ifm_enable_write_previous and wraps N-1→0.
  - Writes are accepted only in IDLE; other states drop them.
  - The pointer clears when a start is accepted.
- Weight memory has N*M words; bias memory has M words. Both use synchronous reads with 1-cycle latency. RISC-V writes are accepted in any state; writing during compute gives undefined results.
- next_busy flag: set by start_to_next, cleared by end_from_next. If both occur in the same cycle, set wins.
- FSM states:
  - IDLE: on start_from_previous, go to BIAS if !next_busy, else WAIT_NEXT.
  - WAIT_NEXT: go to BIAS when next_busy=0.
  - BIAS: issue bias[o], ifm[0], w[o*N]; go to MAC.
  - MAC: N cycles; cycle k consumes product k and issues index k+1. On cycle 0, acc = bias + p0; otherwise acc += pk. Then go to WRITE.
  - WRITE: 1 cycle output strobe. If o<M-1, do o++ and go to BIAS; else go to DONE.
  - DONE: 1 cycle; pulse end_to_previous and start_to_next; go to IDLE.
- start_from_previous outside IDLE is ignored.
- Arithmetic:
  - Full 2·DATA_WIDTH signed product, arithmetic shift right by FRAC_BITS, truncate to DATA_WIDTH.
  - Accumulator is DATA_WIDTH and wraps modulo 2^DATA_WIDTH; there is no saturation.
- Reset:
  - Clears state to IDLE, o, the write pointer, acc and next_busy.
  - Memory contents are retained.
  - Reset during compute aborts with no further writes or pulses.

## Timing
- Reset values: data_out_for_next=0, ofm_enable_write_next=0, ofm_address_write_next=0, end_to_previous=0, start_to_next=0, ready=1.
- Start sampled at edge T, with next stage free:
  - BIAS at T+1.
  - MAC at T+2..T+N+1.
  - First WRITE at T+N+2.
- Per neuron: N+2 cycles. Total from start to DONE: M*(N+2)+1 cycles; for defaults, 84*122+1 = 10249.
- data_out_for_next, ofm_address_write_next and ofm_enable_write_next are registered and valid together for exactly the WRITE cycle.
- ready drops the cycle after a start is accepted and returns in the cycle after DONE.

## Configuration
- FC_F6_RELU_EN:
  - Defined: the written value is 0 when acc is negative, otherwise acc.
  - Undefined: the raw acc is written.
  - Latency is identical either way.

## Test plan
- Bench parameters N=4, M=3; 1.0 = 0x00010000.
- Inputs {1,2,3,4}, row o weights all 1.0, bias 0 → outputs 10.0 (0x000A0000) at addresses 0,1,2; start_to_next 19 cycles after start is sampled.
- Bias = −20.0, weights 1.0: with FC_F6_RELU_EN → 0; without → 0xFFF60000.
- Input 0.5 (0x8000) × weight 0.5 → product 0x4000; verifies shift and truncation.
- next_busy set (no end_from_next): second start → FSM holds in WAIT_NEXT with no writes; end_from_next → BIAS next cycle.
- Assert reset in MAC of neuron 1 → no further ofm_enable_write_next; ready=1; a new start after reloading inputs gives correct results from address 0.
- Write 5 words in IDLE → pointer wraps; word 5 overwrites index 0; writes during MAC have no effect on results.
